// File: rtl/score_ctrl.sv
// score_ctrl: round-robin sequencer for the two scoreboard counters.
// Turns per-team up/down request edges into single well-spaced count pulses,
// drops requests that would push a counter past 0 or MAX_VAL, and runs the
// new-game clear sequence on the counters' active-low reset.
module score_ctrl #(
  parameter int BW        = 7,
  parameter int MAX_VAL   = 99,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2,
  parameter int CLR_LEN   = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    req_up_i,
  input  logic [1:0]    req_down_i,
  input  logic          clear_i,
  input  logic [BW-1:0] cnt0_i,
  input  logic [BW-1:0] cnt1_i,
  output logic [1:0]    up_o,
  output logic [1:0]    down_o,
  output logic          cnt_rst_o,
  output logic          busy_o,
  output logic          drop_o
);

  // The phase timer must hold the longest of the three phase lengths minus one.
  localparam int LEN_PG  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int MAX_LEN = (LEN_PG > CLR_LEN) ? LEN_PG : CLR_LEN;
  localparam int TW      = $clog2(MAX_LEN + 1);

  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);
  localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_LEN - 1);
  localparam logic [BW-1:0] MAX_CNT    = BW'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    req_q, req_d;
  logic          clear_q, clear_d;
  logic [3:0]    pend_q, pend_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          drop_q, drop_d;
  logic          run_q, run_d;

  // Sources are numbered so that bit 0 means "down" and bit 1 means "team 1".
  logic [3:0]    src_in;
  logic [3:0]    rise;
  logic          clear_rise;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [BW-1:0] cnt_sel;
  logic          clamp;
  logic          pulse_on;

  assign src_in     = {req_down_i[1], req_up_i[1], req_down_i[0], req_up_i[0]};
  assign rise       = src_in & ~req_q;
  assign clear_rise = clear_i & ~clear_q;

  // Round-robin pick: first pending source at or after the pointer, wrapping.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!pick_vld && pend_q[ptr_q + 2'(k)]) begin
        pick     = ptr_q + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign cnt_sel = pick[1] ? cnt1_i : cnt0_i;
  assign clamp   = pick[0] ? (cnt_sel == '0) : (cnt_sel == MAX_CNT);

  // Next-state logic; a clear edge overrides whatever the FSM was doing.
  always_comb begin
    state_d = state_q;
    req_d   = src_in;
    clear_d = clear_i;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    drop_d  = 1'b0;
    run_d   = 1'b1;
    if (clear_rise) begin
      state_d = CLEAR;
      pend_d  = '0;
      ptr_d   = '0;
      timer_d = CLR_LAST;
    end else begin
      case (state_q)
        IDLE: begin
          pend_d = pend_q | rise;
          if (pick_vld) begin
            pend_d  = (pend_q & ~(4'b0001 << pick)) | rise;
            ptr_d   = pick + 2'd1;
            grant_d = pick;
            if (clamp) begin
              drop_d = 1'b1;
            end else begin
              state_d = PULSE;
              timer_d = PULSE_LAST;
            end
          end
        end
        PULSE: begin
          pend_d = pend_q | rise;
          if (timer_q == '0) begin
            state_d = GAP;
            timer_d = GAP_LAST;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        GAP: begin
          pend_d = pend_q | rise;
          if (timer_q == '0) begin
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        CLEAR: begin
          if (timer_q == '0) begin
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and bookkeeping registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      clear_q <= 1'b0;
      pend_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      timer_q <= '0;
      drop_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      clear_q <= clear_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      drop_q  <= drop_d;
      run_q   <= run_d;
    end
  end

  assign pulse_on  = (state_q == PULSE);
  assign up_o      = {pulse_on && (grant_q == 2'd2), pulse_on && (grant_q == 2'd0)};
  assign down_o    = {pulse_on && (grant_q == 2'd3), pulse_on && (grant_q == 2'd1)};
  assign cnt_rst_o = run_q && (state_q != CLEAR);
  assign busy_o    = (state_q != IDLE);
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: self-checking bench for score_ctrl. A pair of behavioural
// counters sits on the DUT outputs the way the real scoreboard would, and a
// timestamp-based reference model predicts every output on every cycle.
module tb_score_ctrl;

  localparam int BW        = 7;
  localparam int MAX_VAL   = 99;
  localparam int PULSE_LEN = 2;
  localparam int GAP_LEN   = 2;
  localparam int CLR_LEN   = 4;

  localparam int K_NONE  = 0;
  localparam int K_PULSE = 1;
  localparam int K_CLEAR = 2;

  logic          clk_i;
  logic          rst_i;
  logic [1:0]    req_up_i;
  logic [1:0]    req_down_i;
  logic          clear_i;
  logic [BW-1:0] cnt0_i;
  logic [BW-1:0] cnt1_i;
  logic [1:0]    up_o;
  logic [1:0]    down_o;
  logic          cnt_rst_o;
  logic          busy_o;
  logic          drop_o;

  int checks;
  int errors;

  score_ctrl #(
    .BW(BW), .MAX_VAL(MAX_VAL), .PULSE_LEN(PULSE_LEN),
    .GAP_LEN(GAP_LEN), .CLR_LEN(CLR_LEN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_up_i(req_up_i), .req_down_i(req_down_i),
    .clear_i(clear_i), .cnt0_i(cnt0_i), .cnt1_i(cnt1_i), .up_o(up_o),
    .down_o(down_o), .cnt_rst_o(cnt_rst_o), .busy_o(busy_o), .drop_o(drop_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Environment counters: count once per pulse rising edge, held at zero while
  // the DUT keeps their reset low, and preloadable so boundaries are reachable.
  logic [BW-1:0] ctr0, ctr1, load0, load1;
  logic [1:0]    up_prev, down_prev;
  logic          load_en;

  always @(posedge clk_i or negedge cnt_rst_o) begin
    if (!cnt_rst_o) begin
      ctr0      <= '0;
      ctr1      <= '0;
      up_prev   <= '0;
      down_prev <= '0;
    end else begin
      up_prev   <= up_o;
      down_prev <= down_o;
      if (load_en) begin
        ctr0 <= load0;
        ctr1 <= load1;
      end else begin
        ctr0 <= ctr0 + BW'(up_o[0] & ~up_prev[0]) - BW'(down_o[0] & ~down_prev[0]);
        ctr1 <= ctr1 + BW'(up_o[1] & ~up_prev[1]) - BW'(down_o[1] & ~down_prev[1]);
      end
    end
  end

  assign cnt0_i = ctr0;
  assign cnt1_i = ctr1;

  // Reference model. Instead of tracking FSM states it remembers the current
  // activity (pulse or clear) and the cycle it started in; every output is then
  // a simple window test of the cycle number against that start time.
  bit [3:0] m_prev;
  bit       m_prev_clr;
  bit [3:0] m_pend;
  int       m_ptr, m_kind, m_start, m_src, m_drop_at, t;
  bit       m_started;

  function automatic bit m_idle(input int c);
    if (m_kind == K_PULSE) return c >= m_start + PULSE_LEN + GAP_LEN;
    if (m_kind == K_CLEAR) return c >= m_start + CLR_LEN;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_prev_clr = 1'b0; m_pend = '0; m_ptr = 0;
    m_kind = K_NONE; m_start = 0; m_src = 0; m_drop_at = -1; m_started = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs of cycle t.
  task automatic model_edge(input bit [3:0] s, input bit clr, input int c0, input int c1);
    bit [3:0] rise;
    bit       crise;
    int       g, v;
    bit       is_down;
    rise       = s & ~m_prev;
    crise      = clr & ~m_prev_clr;
    m_prev     = s;
    m_prev_clr = clr;
    m_started  = 1'b1;
    if (crise) begin
      m_kind = K_CLEAR; m_start = t + 1; m_pend = '0; m_ptr = 0;
    end else if (!(m_kind == K_CLEAR && !m_idle(t))) begin
      if (m_idle(t) && m_pend != 0) begin
        g = -1;
        for (int k = 0; k < 4; k++)
          if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        m_pend[g] = 1'b0;
        m_ptr     = (g + 1) % 4;
        v         = (g >= 2) ? c1 : c0;
        is_down   = (g % 2) == 1;
        if ((is_down && v == 0) || (!is_down && v == MAX_VAL)) begin
          m_drop_at = t + 1;
        end else begin
          m_kind = K_PULSE; m_start = t + 1; m_src = g;
        end
      end
      m_pend = m_pend | rise;
    end
  endtask

  // Expected {up_o, down_o, cnt_rst_o, busy_o, drop_o} for the current cycle.
  function automatic logic [6:0] model_expect();
    logic [1:0] eu, ed;
    logic       er, eb, edr;
    eu = '0; ed = '0;
    if (m_kind == K_PULSE && t >= m_start && t < m_start + PULSE_LEN) begin
      if (m_src % 2 == 0) eu[m_src / 2] = 1'b1;
      else                ed[m_src / 2] = 1'b1;
    end
    eb  = !m_idle(t);
    er  = m_started && !(m_kind == K_CLEAR && t < m_start + CLR_LEN);
    edr = (m_drop_at == t);
    return {eu, ed, er, eb, edr};
  endfunction

  // Single comparison point; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Observation accumulators used by the multi-cycle sequences.
  int       drop_seen, rst_low_seen, pulse_rises;
  int       rise_src[$];
  int       rise_time[$];
  logic [3:0] last_pulse;

  // One clock cycle: update the model from the inputs present now, cross the
  // edge, then compare every DUT output against the model 1 unit later.
  task automatic step();
    bit [3:0]   s;
    logic [3:0] now_pulse;
    s = {req_down_i[1], req_up_i[1], req_down_i[0], req_up_i[0]};
    if (!rst_i) model_reset();
    else        model_edge(s, clear_i, int'(cnt0_i), int'(cnt1_i));
    t++;
    @(posedge clk_i);
    #1;
    checkOutput("cycle", {25'b0, up_o, down_o, cnt_rst_o, busy_o, drop_o}, {25'b0, model_expect()});
    now_pulse = {down_o[1], up_o[1], down_o[0], up_o[0]};
    for (int i = 0; i < 4; i++) begin
      if (now_pulse[i] && !last_pulse[i]) begin
        pulse_rises++;
        rise_src.push_back(i);
        rise_time.push_back(t);
      end
    end
    last_pulse = now_pulse;
    drop_seen    += int'(drop_o);
    rst_low_seen += int'(!cnt_rst_o);
  endtask

  // Drive the request and clear levels for the coming cycle, then clock once.
  task automatic applyStimulus(input logic [1:0] up, input logic [1:0] dn, input logic clr);
    req_up_i   = up;
    req_down_i = dn;
    clear_i    = clr;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_counters(input int a, input int b);
    load0   = BW'(a);
    load1   = BW'(b);
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic clear_obs();
    drop_seen = 0; rst_low_seen = 0; pulse_rises = 0;
    rise_src.delete();
    rise_time.delete();
  endtask

  // Single-request vectors: source, counter preload, outputs expected two
  // cycles after the request edge, and counter values once the FSM is idle.
  typedef struct {
    logic [3:0] src;
    int         c0, c1;
    logic [1:0] eu, ed;
    logic       edrop;
    int         f0, f1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, v1;
    checks = 0; errors = 0; t = 0;
    last_pulse = '0;
    clear_obs();
    model_reset();
    rst_i = 1'b0; req_up_i = '0; req_down_i = '0; clear_i = 1'b0;
    load_en = 1'b0; load0 = '0; load1 = '0;

    vecs[0] = '{src: 4'b0001, c0: 5,  c1: 5,  eu: 2'b01, ed: 2'b00, edrop: 1'b0, f0: 6,  f1: 5};
    vecs[1] = '{src: 4'b0010, c0: 0,  c1: 7,  eu: 2'b00, ed: 2'b00, edrop: 1'b1, f0: 0,  f1: 7};
    vecs[2] = '{src: 4'b0100, c0: 3,  c1: 99, eu: 2'b00, ed: 2'b00, edrop: 1'b1, f0: 3,  f1: 99};
    vecs[3] = '{src: 4'b1000, c0: 3,  c1: 99, eu: 2'b00, ed: 2'b10, edrop: 1'b0, f0: 3,  f1: 98};
    vecs[4] = '{src: 4'b0100, c0: 50, c1: 98, eu: 2'b10, ed: 2'b00, edrop: 1'b0, f0: 50, f1: 99};
    vecs[5] = '{src: 4'b0010, c0: 1,  c1: 0,  eu: 2'b00, ed: 2'b01, edrop: 1'b0, f0: 0,  f1: 0};
    vecs[6] = '{src: 4'b0001, c0: 99, c1: 0,  eu: 2'b00, ed: 2'b00, edrop: 1'b1, f0: 99, f1: 0};
    vecs[7] = '{src: 4'b1000, c0: 0,  c1: 0,  eu: 2'b00, ed: 2'b00, edrop: 1'b1, f0: 0,  f1: 0};

    // Power-up reset, then release away from the clock edge.
    run(3);
    rst_i = 1'b1;
    step();
    checkOutput("rst_release_cnt_rst", {31'b0, cnt_rst_o}, 32'd1);
    checkOutput("rst_release_busy", {31'b0, busy_o}, 32'd0);

    // Table-driven single requests, including both clamp boundaries.
    foreach (vecs[i]) begin
      load_counters(vecs[i].c0, vecs[i].c1);
      applyStimulus({vecs[i].src[2], vecs[i].src[0]}, {vecs[i].src[3], vecs[i].src[1]}, 1'b0);
      step();
      checkOutput("vec_up", {30'b0, up_o}, {30'b0, vecs[i].eu});
      checkOutput("vec_down", {30'b0, down_o}, {30'b0, vecs[i].ed});
      checkOutput("vec_drop", {31'b0, drop_o}, {31'b0, vecs[i].edrop});
      applyStimulus(2'b00, 2'b00, 1'b0);
      run(3);
      checkOutput("vec_cnt0", {25'b0, ctr0}, 32'(vecs[i].f0));
      checkOutput("vec_cnt1", {25'b0, ctr1}, 32'(vecs[i].f1));
      checkOutput("vec_idle", {31'b0, busy_o}, 32'd0);
    end

    // Asynchronous reset in the middle of a pulse kills outputs at once.
    load_counters(10, 10);
    applyStimulus(2'b01, 2'b00, 1'b0);
    step();
    checkOutput("pre_reset_up", {30'b0, up_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    checkOutput("async_rst_outs", {25'b0, up_o, down_o, cnt_rst_o, busy_o, drop_o}, 32'd0);
    req_up_i = 2'b00;
    run(2);
    rst_i = 1'b1;
    step();
    checkOutput("rst2_cnt_rst", {31'b0, cnt_rst_o}, 32'd1);
    checkOutput("rst2_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst2_cnt0", {25'b0, ctr0}, 32'd0);

    // All four sources rise together: served up0, down0, up1, down1, 5 apart.
    load_counters(10, 10);
    clear_obs();
    applyStimulus(2'b11, 2'b11, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    run(22);
    checkOutput("all4_count", 32'(rise_src.size()), 32'd4);
    if (rise_src.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("all4_order", 32'(rise_src[i]), 32'(i));
        if (i > 0) checkOutput("all4_spacing", 32'(rise_time[i] - rise_time[i-1]), 32'd5);
      end
    end
    checkOutput("all4_cnt0", {25'b0, ctr0}, 32'd10);
    checkOutput("all4_cnt1", {25'b0, ctr1}, 32'd10);

    // Clear during an up0 pulse with up1 still pending.
    load_counters(20, 20);
    applyStimulus(2'b11, 2'b00, 1'b0);
    step();
    checkOutput("clr_pre_up", {30'b0, up_o}, 32'd1);
    clear_obs();
    applyStimulus(2'b11, 2'b00, 1'b1);
    checkOutput("clr_trunc_up", {30'b0, up_o}, 32'd0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    run(10);
    checkOutput("clr_low_cycles", 32'(rst_low_seen), 32'd4);
    checkOutput("clr_no_pulse", 32'(pulse_rises), 32'd0);
    checkOutput("clr_cnt0", {25'b0, ctr0}, 32'd0);
    checkOutput("clr_cnt1", {25'b0, ctr1}, 32'd0);
    checkOutput("clr_idle", {31'b0, busy_o}, 32'd0);

    // A level held high is one request, not twenty.
    load_counters(97, 0);
    clear_obs();
    for (int i = 0; i < 20; i++) applyStimulus(2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    run(6);
    checkOutput("hold_pulses", 32'(pulse_rises), 32'd1);
    checkOutput("hold_cnt0", {25'b0, ctr0}, 32'd98);

    // Thirty separate up0 requests from 97: two land, the rest are dropped.
    load_counters(97, 0);
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'b01, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0);
      run(5);
    end
    checkOutput("sat_cnt0", {25'b0, ctr0}, 32'd99);
    checkOutput("sat_pulses", 32'(pulse_rises), 32'd2);
    checkOutput("sat_drops", 32'(drop_seen), 32'd28);

    // Random traffic against the model, with boundary preloads and clears.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] s;
      s = {req_down_i[1], req_up_i[1], req_down_i[0], req_up_i[0]};
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 3)] ^= 1'b1;
      if (n % 100 == 50) begin
        v0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(96, 99));
        v1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(96, 99));
        load_counters(v0, v1);
      end
      applyStimulus({s[2], s[0]}, {s[3], s[1]}, ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
